cordic_seq_ctrl: RTL and testbench

Sequencing controller for the iterative CORDIC datapath. It accepts a start request and drives the datapath's operand-register load strobe. It then steps the per-iteration enable and iteration index (shift amount / angle-table address) for NUM_ITER cycles, and presents the result with a valid/ready handshake. It sits between the requesting logic and the x/y/z register stage of the CORDIC core.

---
 rtl/cordic_pkg.sv | 6 +
 rtl/cordic_iter_cnt.sv | 17 +
 rtl/cordic_seq_ctrl.sv | 55 +++++
 tb/tb_cordic_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC sequencing types and default sizing constants.
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} cordic_seq_state_t;
  localparam int NUM_ITER_DEF = 16;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/cordic_iter_cnt.sv
// cordic_iter_cnt: clearable iteration index counter, wraps to 0 after its terminal count NUM_ITER-1.
module cordic_iter_cnt #(
  parameter int NUM_ITER = 16,
  localparam int IDX_WIDTH = $clog2(NUM_ITER)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 tc
);
  assign tc = idx == IDX_WIDTH'(NUM_ITER - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) idx <= '0;
    else idx <= (clr || (inc && tc)) ? '0 : inc ? idx + 1'b1 : idx;
endmodule

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: load/iterate/present sequencer for the iterative CORDIC datapath.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int NUM_ITER = NUM_ITER_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  localparam int IDX_WIDTH = $clog2(NUM_ITER)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic                 out_ready_in,
  output logic                 ready_out,
  output logic                 busy_out,
  output logic                 load_out,
  output logic                 iter_en_out,
  output logic [IDX_WIDTH-1:0] iter_idx_out,
  output logic                 out_valid_out,
  output logic [CNT_WIDTH-1:0] done_cnt_out
);
  cordic_seq_state_t state, state_nxt;
  logic tc, handshake;
  assign handshake = state == DONE && out_ready_in;
  assign ready_out = state == IDLE || handshake;
  assign busy_out = state != IDLE;
  assign load_out = state == LOAD;
  assign iter_en_out = state == ITER;
  assign out_valid_out = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // abort wins over everything, including a handshake with a pending start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start_in ? LOAD : IDLE;
      LOAD: state_nxt = ITER;
      ITER: state_nxt = tc ? DONE : ITER;
      DONE: state_nxt = out_ready_in ? (start_in ? LOAD : IDLE) : DONE;
    endcase
    if (abort_in) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) done_cnt_out <= '0;
    else if (handshake && !abort_in) done_cnt_out <= done_cnt_out + 1'b1;
  cordic_iter_cnt #(.NUM_ITER(NUM_ITER)) u_iter_cnt (
    .clk(clk),
    .rst(rst),
    .clr(abort_in),
    .inc(iter_en_out),
    .idx(iter_idx_out),
    .tc(tc)
  );
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: directed bench with a cycle-position model of the sequencer plus literal checkpoints.
module tb_cordic_seq_ctrl;
  localparam int N = 16;
  logic clk = 0, rst = 0, start_in = 0, abort_in = 0, out_ready_in = 0;
  logic ready, busy, load, iter_en, valid;
  logic [3:0] idx;
  logic [15:0] cnt;
  logic ready_w, busy_w, load_w, iter_en_w, valid_w;
  logic [3:0] idx_w;
  logic [1:0] cnt_w;
  int pass_cnt = 0, total = 0;
  int pos = -1, mcnt = 0;
  cordic_seq_ctrl #(.NUM_ITER(N), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in), .out_ready_in(out_ready_in),
    .ready_out(ready), .busy_out(busy), .load_out(load), .iter_en_out(iter_en),
    .iter_idx_out(idx), .out_valid_out(valid), .done_cnt_out(cnt)
  );
  cordic_seq_ctrl #(.NUM_ITER(N), .CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in), .out_ready_in(out_ready_in),
    .ready_out(ready_w), .busy_out(busy_w), .load_out(load_w), .iter_en_out(iter_en_w),
    .iter_idx_out(idx_w), .out_valid_out(valid_w), .done_cnt_out(cnt_w)
  );
  always #5 clk = ~clk;
  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // pos: -1 idle, 0 load cycle, 1..N iteration cycles, N+1 result presented
  always @(posedge clk or posedge rst)
    if (rst) begin
      pos = -1;
      mcnt = 0;
    end else if (abort_in) pos = -1;
    else if (pos < 0) pos = start_in ? 0 : -1;
    else if (pos <= N) pos++;
    else if (out_ready_in) begin
      mcnt++;
      pos = start_in ? 0 : -1;
    end
  always @(negedge clk)
    if (!rst) begin
      check("busy", busy, pos >= 0);
      check("load", load, pos == 0);
      check("iter_en", iter_en, pos >= 1 && pos <= N);
      check("idx", idx, (pos >= 1 && pos <= N) ? pos - 1 : 0);
      check("valid", valid, pos == N + 1);
      check("ready", ready, pos < 0 || (pos == N + 1 && out_ready_in));
      check("cnt", cnt, mcnt % 65536);
      check("cnt_w", cnt_w, mcnt % 4);
      check("valid_w", valid_w, pos == N + 1);
      check("idx_w", idx_w, (pos >= 1 && pos <= N) ? pos - 1 : 0);
      check("exclusive", 32'(load) + 32'(iter_en) + 32'(valid) <= 1, 1);
    end
  initial begin
    int vcnt, loads[$];
    int exp_w[5] = '{1, 2, 3, 0, 1};
    #3 rst = 1;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_outs", {load, iter_en, valid, idx, cnt}, 0);
    step(); step();
    rst = 0;
    repeat (3) begin
      check("idle_load", load, 0);
      step();
    end
    // single operation
    start_in = 1; out_ready_in = 1;
    step();
    start_in = 0;
    check("single_load", load, 1);
    step();
    for (int i = 0; i < N; i++) begin
      check("single_iter_en", iter_en, 1);
      check("single_idx", idx, i);
      step();
    end
    check("single_valid", valid, 1);
    step();
    check("single_cnt", cnt, 1);
    check("single_idle", busy, 0);
    // backpressure, with start pulses during ITER that must be dropped
    out_ready_in = 0; start_in = 1;
    step();
    start_in = 0;
    repeat (5) step();
    start_in = 1;
    step();
    start_in = 0;
    for (int k = 0; k < 40 && !valid; k++) step();
    check("bp_valid_reached", valid, 1);
    vcnt = 0;
    repeat (5) begin
      vcnt += int'(valid);
      step();
    end
    out_ready_in = 1;
    vcnt += int'(valid);
    step();
    check("bp_valid_cycles", vcnt, 6);
    check("bp_cnt", cnt, 2);
    check("bp_no_requeue", busy, 0);
    // back-to-back
    start_in = 1;
    step();
    for (int k = 0; k < 54; k++) begin
      if (load) loads.push_back(k);
      step();
    end
    check("b2b_loads", loads.size(), 3);
    if (loads.size() == 3) begin
      check("b2b_gap1", loads[1] - loads[0], 18);
      check("b2b_gap2", loads[2] - loads[1], 18);
    end
    check("b2b_cnt", cnt, 5);
    check("b2b_next_load", load, 1);
    start_in = 0;
    for (int k = 0; k < 40 && busy; k++) step();
    check("b2b_drain", busy, 0);
    check("b2b_cnt_final", cnt, 6);
    // abort at idx 7
    start_in = 1;
    step();
    start_in = 0;
    for (int k = 0; k < 40 && !(iter_en && idx == 7); k++) step();
    check("abort_reach7", idx, 7);
    abort_in = 1;
    step();
    abort_in = 0;
    check("abort_idle", busy, 0);
    check("abort_idx", idx, 0);
    vcnt = 0;
    repeat (20) begin
      vcnt += int'(valid);
      step();
    end
    check("abort_no_valid", vcnt, 0);
    check("abort_cnt", cnt, 6);
    // abort coincident with handshake
    out_ready_in = 0; start_in = 1;
    step();
    start_in = 0;
    for (int k = 0; k < 40 && !valid; k++) step();
    check("abort_hs_valid", valid, 1);
    out_ready_in = 1; abort_in = 1; start_in = 1;
    step();
    abort_in = 0; start_in = 0;
    check("abort_hs_cnt", cnt, 6);
    check("abort_hs_idle", busy, 0);
    // counter wrap on the 2-bit instance
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst2_cnt", cnt, 0);
    check("rst2_ready", ready, 1);
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      start_in = 1;
      step();
      start_in = 0;
      for (int k = 0; k < 40 && busy; k++) step();
      check("wrap_cnt_w", cnt_w, exp_w[i]);
    end
    check("wrap_cnt", cnt, 5);
    // reset during ITER at idx 10
    start_in = 1;
    step();
    start_in = 0;
    for (int k = 0; k < 40 && !(iter_en && idx == 10); k++) step();
    check("rst_iter_reach10", idx, 10);
    #2 rst = 1;
    #1;
    check("rst_iter_busy", busy, 0);
    check("rst_iter_idx", idx, 0);
    check("rst_iter_cnt", cnt, 0);
    step();
    rst = 0;
    start_in = 1;
    step();
    start_in = 0;
    check("restart_load", load, 1);
    step();
    check("restart_idx0", {iter_en, idx}, {1'b1, 4'd0});
    for (int k = 0; k < 40 && busy; k++) step();
    check("restart_cnt", cnt, 1);
    step();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
